// File: rtl/br_resolve_pred_pkg.sv
// Shared constants for the EX-stage branch resolution unit: control-word
// field positions, branch type codes and branch subtype codes.
package br_pkg;

    localparam int CTR_W        = 32;
    localparam int CTR_TYPE_LSB = 0;
    localparam int CTR_TYPE_MSB = 3;
    localparam int CTR_SUB_LSB  = 7;
    localparam int CTR_SUB_MSB  = 11;

    typedef logic [CTR_TYPE_MSB-CTR_TYPE_LSB:0] br_type_t;
    typedef logic [CTR_SUB_MSB-CTR_SUB_LSB:0]   br_sub_t;

    localparam br_type_t BR_TYPE_COND = 4'd1;
    localparam br_type_t BR_TYPE_JUMP = 4'd8;

    localparam br_sub_t BR_SUB_B    = 5'd0;
    localparam br_sub_t BR_SUB_BEQ  = 5'd1;
    localparam br_sub_t BR_SUB_BNE  = 5'd2;
    localparam br_sub_t BR_SUB_BLT  = 5'd3;
    localparam br_sub_t BR_SUB_BGE  = 5'd4;
    localparam br_sub_t BR_SUB_BLTU = 5'd5;
    localparam br_sub_t BR_SUB_BGEU = 5'd6;
    localparam br_sub_t BR_SUB_JIRL = 5'd0;

endpackage

// File: rtl/br_resolve_pred_if.sv
// EX-stage branch bundle plus the IF-stage BHT lookup and redirect/perf outputs.
interface br_resolve_pred_if #(
    parameter int DATA_W = 32,
    parameter int PERF_W = 32
);
    import br_pkg::*;

    logic              ex_valid;
    logic              ex_stall;
    logic [CTR_W-1:0]  ctr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rrj;
    logic [DATA_W-1:0] alu1;
    logic [DATA_W-1:0] alu2;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_pc;
    logic [DATA_W-1:0] if_pc;
    logic              if_pred_taken;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic [PERF_W-1:0] perf_br_cnt;
    logic [PERF_W-1:0] perf_miss_cnt;

    modport master (
        output ex_valid, ex_stall, ctr, pc, imm, rrj, alu1, alu2,
               pred_taken, pred_pc, if_pc,
        input  if_pred_taken, redirect_valid, redirect_pc,
               perf_br_cnt, perf_miss_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, ctr, pc, imm, rrj, alu1, alu2,
               pred_taken, pred_pc, if_pc,
        output if_pred_taken, redirect_valid, redirect_pc,
               perf_br_cnt, perf_miss_cnt
    );

endinterface

// File: rtl/br_resolve_pred_bht.sv
// Branch history table of saturating counters: combinational read port,
// single increment/decrement write port, weakly-not-taken reset value.
module bht_sat #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            if (wr_inc) begin
                if (cnt_q[wr_idx] != CNT_MAX)
                    cnt_d[wr_idx] = cnt_q[wr_idx] + CNT_W'(1);
            end else if (cnt_q[wr_idx] != '0) begin
                cnt_d[wr_idx] = cnt_q[wr_idx] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst)
                cnt_q[i] <= CNT_INIT;
            else
                cnt_q[i] <= cnt_d[i];
        end
    end

    // Reads the registered array, so a same-cycle update is not visible yet.
    assign rd_taken = cnt_q[rd_idx][CNT_W-1];

endmodule

// File: rtl/br_resolve_pred.sv
// EX-stage branch resolution: evaluates conditions and targets, compares with
// the fetch prediction, issues a one-cycle registered redirect and trains the BHT.
module br_resolve_pred
    import br_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int PERF_W    = 32
) (
    input logic              clk,
    input logic              rst,
    br_resolve_pred_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    br_type_t          br_type;
    br_sub_t           br_sub;
    logic              is_cond;
    logic              is_jump;
    logic              active;
    logic              resolve;
    logic              taken;
    logic              mispredict;
    logic              bht_wr_en;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] fall_pc;

    logic              redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_miss_q, perf_miss_d;

    logic unused_bits;
    assign unused_bits = ^{bus.ctr[CTR_W-1:CTR_SUB_MSB+1], bus.ctr[CTR_SUB_LSB-1:CTR_TYPE_MSB+1],
                           bus.if_pc[DATA_W-1:IDX_W+2], bus.if_pc[1:0]};

    assign br_type = bus.ctr[CTR_TYPE_MSB:CTR_TYPE_LSB];
    assign br_sub  = bus.ctr[CTR_SUB_MSB:CTR_SUB_LSB];
    assign is_cond = (br_type == BR_TYPE_COND);
    assign is_jump = (br_type == BR_TYPE_JUMP);

    // The redirect cycle carries a wrong-path instruction, so it is never active.
    assign active  = bus.ex_valid & ~bus.ex_stall & ~redirect_valid_q;
    assign resolve = active & (is_cond | is_jump);

    always_comb begin
        taken = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else if (is_cond) begin
            case (br_sub)
                BR_SUB_B:    taken = 1'b1;
                BR_SUB_BEQ:  taken = (bus.alu1 == bus.alu2);
                BR_SUB_BNE:  taken = (bus.alu1 != bus.alu2);
                BR_SUB_BLT:  taken = ($signed(bus.alu1) <  $signed(bus.alu2));
                BR_SUB_BGE:  taken = ($signed(bus.alu1) >= $signed(bus.alu2));
                BR_SUB_BLTU: taken = (bus.alu1 <  bus.alu2);
                BR_SUB_BGEU: taken = (bus.alu1 >= bus.alu2);
                default:     taken = 1'b0;
            endcase
        end
    end

    assign target     = (is_jump && br_sub == BR_SUB_JIRL) ? bus.rrj + bus.imm : bus.pc + bus.imm;
    assign fall_pc    = bus.pc + DATA_W'(4);
    assign mispredict = resolve & ((taken != bus.pred_taken) | (taken & (target != bus.pred_pc)));
    assign bht_wr_en  = resolve & is_cond & (br_sub >= BR_SUB_BEQ) & (br_sub <= BR_SUB_BGEU);

    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (mispredict)
            redirect_pc_d = taken ? target : fall_pc;
        perf_br_d   = perf_br_q + PERF_W'(resolve);
        perf_miss_d = perf_miss_q + PERF_W'(mispredict);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            perf_br_q        <= '0;
            perf_miss_q      <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            perf_br_q        <= perf_br_d;
            perf_miss_q      <= perf_miss_d;
        end
    end

    bht_sat #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.if_pc[IDX_W+1:2]),
        .rd_taken (bus.if_pred_taken),
        .wr_en    (bht_wr_en),
        .wr_idx   (bus.pc[IDX_W+1:2]),
        .wr_inc   (taken)
    );

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.perf_br_cnt    = perf_br_q;
    assign bus.perf_miss_cnt  = perf_miss_q;

endmodule

// File: tb/tb_br_resolve_pred.sv
// Randomised self-checking bench for br_resolve_pred against a behavioural
// model (counter array, redirect register and perf counts) held in the bench.
module tb_br_resolve_pred;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state: counter values as plain integers 0..3
    int          m_bht [64];
    bit          m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_br;
    logic [31:0] m_miss;

    br_resolve_pred_if #(.DATA_W(32), .PERF_W(32)) bus ();

    br_resolve_pred #(
        .DATA_W    (32),
        .BHT_DEPTH (64),
        .CNT_W     (2),
        .PERF_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_rv   = 1'b0;
        m_rpc  = '0;
        m_br   = '0;
        m_miss = '0;
    endtask

    // Next-state rules written straight from the branch semantics
    task automatic model_step();
        int          typ;
        int          sub;
        bit          act;
        bit          res;
        bit          tkn;
        bit          miss;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [31:0] tgt;
        int          idx;
        if (rst) begin
            model_reset();
            return;
        end
        typ = int'(bus.ctr[3:0]);
        sub = int'(bus.ctr[11:7]);
        act = bus.ex_valid && !bus.ex_stall && !m_rv;
        res = act && (typ == 1 || typ == 8);
        sa  = longint'(signed'(bus.alu1));
        sb  = longint'(signed'(bus.alu2));
        ua  = longint'(bus.alu1);
        ub  = longint'(bus.alu2);
        tkn = 1'b0;
        if (typ == 8) tkn = 1'b1;
        else if (typ == 1) begin
            case (sub)
                0: tkn = 1'b1;
                1: tkn = (ua == ub);
                2: tkn = (ua != ub);
                3: tkn = (sa < sb);
                4: tkn = (sa >= sb);
                5: tkn = (ua < ub);
                6: tkn = (ua >= ub);
                default: tkn = 1'b0;
            endcase
        end
        tgt  = (typ == 8 && sub == 0) ? bus.rrj + bus.imm : bus.pc + bus.imm;
        miss = res && ((tkn != bus.pred_taken) || (tkn && tgt != bus.pred_pc));
        if (miss) m_rpc = tkn ? tgt : bus.pc + 32'd4;
        m_rv = miss;
        if (res) m_br = m_br + 1;
        if (miss) m_miss = m_miss + 1;
        if (res && typ == 1 && sub >= 1 && sub <= 6) begin
            idx = int'(bus.pc[7:2]);
            if (tkn) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else     m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
    endtask

    task automatic apply_stimulus(input bit v, input bit st, input int typ, input int sub,
                                  input logic [31:0] pc_v, input logic [31:0] imm_v,
                                  input logic [31:0] rrj_v, input logic [31:0] a1,
                                  input logic [31:0] a2, input bit pt,
                                  input logic [31:0] ppc, input logic [31:0] ifpc, input bit r);
        logic [31:0] c;
        c          = $urandom;
        c[3:0]     = typ[3:0];
        c[11:7]    = sub[4:0];
        bus.ex_valid   = v;
        bus.ex_stall   = st;
        bus.ctr        = c;
        bus.pc         = pc_v;
        bus.imm        = imm_v;
        bus.rrj        = rrj_v;
        bus.alu1       = a1;
        bus.alu2       = a2;
        bus.pred_taken = pt;
        bus.pred_pc    = ppc;
        bus.if_pc      = ifpc;
        rst            = r;
        @(negedge clk);
    endtask

    task automatic check_output();
        vectors++;
        cmp("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
        cmp("redirect_pc", bus.redirect_pc, m_rpc);
        cmp("perf_br_cnt", bus.perf_br_cnt, m_br);
        cmp("perf_miss_cnt", bus.perf_miss_cnt, m_miss);
        cmp("if_pred_taken", 32'(bus.if_pred_taken), 32'(m_bht[int'(bus.if_pc[7:2])] >= 2));
    endtask

    task automatic step_clock();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        check_output();
        step_clock();
    endtask

    task automatic idle(input logic [31:0] ifpc);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ifpc, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_cycle();
        int          typ;
        int          sub;
        logic [31:0] pc_v;
        logic [31:0] imm_v;
        logic [31:0] rrj_v;
        logic [31:0] tgt;
        logic [31:0] ifpc;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: typ = 1;
            5, 6:          typ = 8;
            default:       typ = int'($urandom_range(0, 15));
        endcase
        sub   = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
        pc_v  = 32'h8000 + 32'($urandom_range(0, 15) << 2);
        imm_v = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
        rrj_v = $urandom;
        tgt   = (typ == 8 && sub == 0) ? rrj_v + imm_v : pc_v + imm_v;
        ifpc  = ($urandom_range(0, 1) != 0) ? pc_v : 32'h8000 + 32'($urandom_range(0, 15) << 2);
        apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, typ, sub,
                       pc_v, imm_v, rrj_v, pick_operand(), pick_operand(),
                       $urandom_range(0, 1) != 0,
                       ($urandom_range(0, 3) != 0) ? tgt : $urandom,
                       ifpc, $urandom_range(0, 149) == 0);
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_stall = 1'b0; bus.ctr = '0; bus.pc = '0; bus.imm = '0;
        bus.rrj = '0; bus.alu1 = '0; bus.alu2 = '0; bus.pred_taken = 1'b0; bus.pred_pc = '0;
        bus.if_pc = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Mispredicting branch during reset must not redirect
        apply_stimulus(1, 0, 1, 1, 32'h1000, 32'h40, 0, 5, 5, 0, 0, 32'h1000, 1);
        step_clock();
        idle(32'h1000);
        cmp("reset redirect_valid", 32'(bus.redirect_valid), 0);
        cmp("reset perf_br", bus.perf_br_cnt, 0);
        cmp("reset perf_miss", bus.perf_miss_cnt, 0);
        cmp("reset if_pred", 32'(bus.if_pred_taken), 0);
        cycle();

        // BEQ taken, predicted not-taken
        apply_stimulus(1, 0, 1, 1, 32'h1000, 32'h40, 0, 5, 5, 0, 0, 32'h1000, 0);
        cmp("beq collision if_pred", 32'(bus.if_pred_taken), 0);
        cycle();
        idle(32'h1000);
        cmp("beq redirect_valid", 32'(bus.redirect_valid), 1);
        cmp("beq redirect_pc", bus.redirect_pc, 32'h1040);
        cmp("beq if_pred", 32'(bus.if_pred_taken), 1);
        cmp("beq perf_br", bus.perf_br_cnt, 1);
        cmp("beq perf_miss", bus.perf_miss_cnt, 1);
        cycle();

        // BLTU not taken vs BLT taken on the same operands
        apply_stimulus(1, 0, 1, 5, 32'h1200, 32'h20, 0, 32'hFFFF_FFFF, 1, 0, 32'h1220, 32'h1200, 0);
        cycle();
        apply_stimulus(1, 0, 1, 3, 32'h1200, 32'h20, 0, 32'hFFFF_FFFF, 1, 1, 32'h1220, 32'h1200, 0);
        cycle();
        idle(32'h1200);
        cmp("signed cmp redirect_valid", 32'(bus.redirect_valid), 0);
        cmp("signed cmp perf_br", bus.perf_br_cnt, 3);
        cmp("signed cmp perf_miss", bus.perf_miss_cnt, 1);
        cycle();

        // JIRL with wrong predicted target
        apply_stimulus(1, 0, 8, 0, 32'h4000, 32'h10, 32'h2000, 0, 0, 1, 32'h3000, 32'h4000, 0);
        cycle();
        idle(32'h4000);
        cmp("jirl redirect_valid", 32'(bus.redirect_valid), 1);
        cmp("jirl redirect_pc", bus.redirect_pc, 32'h2010);
        cmp("jirl perf_miss", bus.perf_miss_cnt, 2);
        cycle();

        // Saturation up then down at index 1
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 1, 2, 32'h1104, 32'h8, 0, 1, 2, 1, 32'h110C, 32'h1104, 0);
            cycle();
        end
        idle(32'h1104);
        cmp("bne saturated if_pred", 32'(bus.if_pred_taken), 1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 1, 2, 32'h1104, 32'h8, 0, 3, 3, 0, 0, 32'h1104, 0);
            cycle();
        end
        idle(32'h1104);
        cmp("bne floor if_pred", 32'(bus.if_pred_taken), 0);
        cmp("bne perf_br", bus.perf_br_cnt, 13);
        cmp("bne redirect_valid", 32'(bus.redirect_valid), 0);
        cycle();

        // Mispredict, then another mispredict in the wrong-path cycle
        apply_stimulus(1, 0, 1, 1, 32'h5000, 32'h100, 0, 7, 7, 0, 0, 32'h5000, 0);
        cycle();
        apply_stimulus(1, 0, 1, 2, 32'h6000, 32'h10, 0, 1, 2, 0, 0, 32'h6000, 0);
        cmp("wrong-path redirect_pc", bus.redirect_pc, 32'h5100);
        cmp("wrong-path perf_miss", bus.perf_miss_cnt, 3);
        cycle();
        idle(32'h6000);
        cmp("no back-to-back redirect", 32'(bus.redirect_valid), 0);
        cmp("wrong-path perf_br", bus.perf_br_cnt, 14);
        cycle();

        // Stalled mispredict is ignored
        apply_stimulus(1, 1, 1, 2, 32'h6000, 32'h10, 0, 1, 2, 0, 0, 32'h6000, 0);
        cycle();
        idle(32'h6000);
        cmp("stall redirect_valid", 32'(bus.redirect_valid), 0);
        cmp("stall perf_miss", bus.perf_miss_cnt, 3);
        cycle();

        // Reset right after a mispredict
        apply_stimulus(1, 0, 1, 1, 32'h7000, 32'h20, 0, 0, 0, 0, 0, 32'h7000, 0);
        cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000, 1);
        cmp("pre-reset redirect_valid", 32'(bus.redirect_valid), 1);
        cycle();
        for (int i = 0; i < 64; i++) begin
            idle(32'(i << 2));
            cmp("post-reset if_pred", 32'(bus.if_pred_taken), 0);
            cmp("post-reset redirect_valid", 32'(bus.redirect_valid), 0);
            cmp("post-reset perf_br", bus.perf_br_cnt, 0);
            cycle();
        end

        for (int i = 0; i < 3000; i++) random_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
